// File: rtl/xor_bus_master_if.sv
// Operand/result streams and the register bus between xor_bus_master and the XOR bus slave.
interface xor_bus_master_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_a;
    logic       in_b;
    logic       out_valid;
    logic       out_ready;
    logic       out_y;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;

    modport master (
        input  in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
        output in_ready, out_valid, out_y, write_address, write_data, write_en,
               read_address, read_en
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, write_rdy, read_data, read_rdy,
        input  in_ready, out_valid, out_y, write_address, write_data, write_en,
               read_address, read_en
    );
endinterface

// File: rtl/xor_bus_master.sv
// Turns each (a, b) operand pair into a write/write/poll/read sequence on the XOR slave bus
// and returns a ^ b; sticky error on a stalled slave, wrapping count of finished pairs.
module xor_bus_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    xor_bus_master_if.master bus,
    output logic             err,
    output logic [CNT_W-1:0] done_count
);
    localparam int unsigned   TW   = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, WR_A, WR_B, POLL, RD_Y, OUT, ERR
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_a;
    logic             r_b;
    logic             r_y;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_done;
    logic             w_waiting;
    logic             w_progress;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_y     <= 1'b0;
            r_timer <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_timer <= '0;
            else if (w_waiting)
                r_timer <= r_timer + 1'b1;
            if (r_state == IDLE && bus.in_valid) begin
                r_a <= bus.in_a;
                r_b <= bus.in_b;
            end
            if (r_state == RD_Y && bus.read_rdy)
                r_y <= bus.read_data;
            if (r_state == OUT && bus.out_ready)
                r_done <= r_done + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_waiting  = 1'b0;
        w_progress = 1'b0;
        case (r_state)
            IDLE: if (bus.in_valid) w_next = WR_A;
            WR_A: begin
                w_waiting  = 1'b1;
                w_progress = bus.write_rdy;
                if (w_progress) w_next = WR_B;
            end
            WR_B: begin
                w_waiting  = 1'b1;
                w_progress = bus.write_rdy;
                if (w_progress) w_next = POLL;
            end
            POLL: begin
                w_waiting  = 1'b1;
                w_progress = bus.read_rdy && bus.read_data;
                if (w_progress) w_next = RD_Y;
            end
            RD_Y: if (bus.read_rdy) w_next = OUT;
            OUT:  if (bus.out_ready) w_next = IDLE;
            ERR:  w_next = ERR;
            default: w_next = IDLE;
        endcase
        // progress seen on the last allowed cycle takes priority over the timeout
        if (w_waiting && !w_progress && r_timer == TMAX)
            w_next = ERR;
    end

    always_comb begin
        bus.in_ready      = 1'b0;
        bus.out_valid     = 1'b0;
        bus.out_y         = 1'b0;
        bus.write_address = '0;
        bus.write_data    = 1'b0;
        bus.write_en      = 1'b0;
        bus.read_address  = '0;
        bus.read_en       = 1'b0;
        err               = 1'b0;
        case (r_state)
            IDLE: bus.in_ready = 1'b1;
            WR_A: begin
                bus.write_address = 3'd4;
                bus.write_data    = r_a;
                bus.write_en      = 1'b1;
            end
            WR_B: begin
                bus.write_address = 3'd5;
                bus.write_data    = r_b;
                bus.write_en      = 1'b1;
            end
            POLL: bus.read_address = 3'd2;
            RD_Y: begin
                bus.read_address = 3'd3;
                bus.read_en      = 1'b1;
            end
            OUT: begin
                bus.out_valid = 1'b1;
                bus.out_y     = r_y;
            end
            ERR: err = 1'b1;
            default: ;
        endcase
    end

    assign done_count = r_done;
endmodule

// File: tb/tb_xor_bus_master.sv
// Bench for xor_bus_master: behavioural XOR slave, queue-based transaction model, directed
// corner cases plus a randomized run; a CNT_W=2 copy shadows the same traffic for wrap checks.
module tb_xor_bus_master;
    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       RST;
    logic       err;
    logic       err2;
    logic [7:0] done_count;
    logic [1:0] done_count2;

    xor_bus_master_if bus ();
    xor_bus_master_if bus2 ();

    xor_bus_master #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .CLK(clk), .RST(RST), .bus(bus.master), .err(err), .done_count(done_count)
    );
    xor_bus_master #(.TIMEOUT(TO), .CNT_W(2)) dut2 (
        .CLK(clk), .RST(RST), .bus(bus2.master), .err(err2), .done_count(done_count2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_a      = bus.in_a;
    assign bus2.in_b      = bus.in_b;
    assign bus2.out_ready = bus.out_ready;
    assign bus2.write_rdy = bus.write_rdy;
    assign bus2.read_rdy  = bus.read_rdy;
    assign bus2.read_data = bus.read_data;

    always #5 clk = ~clk;

    bit rnd;
    bit hold_status;
    bit ideal;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural slave: operands at 4/5, status at 2 (after an optional delay), a^b at 3.
    logic        s_a, s_b, s_have;
    int unsigned s_dly;

    always @(posedge clk) begin
        if (RST) begin
            s_a <= 1'b0; s_b <= 1'b0; s_have <= 1'b0; s_dly <= 0;
        end else begin
            if (bus.write_en && bus.write_rdy) begin
                if (bus.write_address == 3'd4) s_a <= bus.write_data;
                if (bus.write_address == 3'd5) begin
                    s_b    <= bus.write_data;
                    s_have <= 1'b1;
                    s_dly  <= rnd ? $urandom_range(0, 3) : 0;
                end
            end else if (s_dly != 0) begin
                s_dly <= s_dly - 1;
            end
            if (bus.read_en && bus.read_rdy && bus.read_address == 3'd3) s_have <= 1'b0;
        end
    end

    always_comb begin
        bus.read_data = 1'b0;
        if (bus.read_address == 3'd2)
            bus.read_data = s_have && (s_dly == 0) && !hold_status;
        else if (bus.read_address == 3'd3)
            bus.read_data = s_a ^ s_b;
    end

    // Transaction model: each accepted pair owes W4(a), W5(b), R3 on the bus and a^b on the output.
    logic [4:0]  exp_bus[$];
    logic        exp_y[$];
    int unsigned acc_cyc[$];
    int unsigned cyc = 0;
    int unsigned n_done = 0;
    logic        p_ov, p_or, p_y, p_we, p_wr, p_wd;
    logic [2:0]  p_wa;
    logic [4:0]  m_ev;
    logic        m_y;
    int unsigned m_acc;

    always @(negedge clk) begin
        if (RST) begin
            exp_bus.delete(); exp_y.delete(); acc_cyc.delete();
            n_done = 0; p_ov = 1'b0; p_or = 1'b0; p_y = 1'b0;
            p_we = 1'b0; p_wr = 1'b0; p_wa = '0; p_wd = 1'b0;
        end else begin
            cyc++;
            check("done_count", done_count, 8'(n_done));
            check("done_count_w2", done_count2, 2'(n_done));
            check("valid_ready_excl", bus.out_valid & bus.in_ready, 0);
            if (bus.in_ready)
                check("idle_bus_quiet", {bus.write_en, bus.read_en, bus.read_address}, 0);
            if (bus.read_address == 3'd2) check("poll_no_pop", bus.read_en, 0);
            if (p_ov && !p_or)
                check("out_hold", {bus.out_valid, bus.out_y}, {1'b1, p_y});
            if (p_we && !p_wr && !err)
                check("wr_hold", {bus.write_en, bus.write_address, bus.write_data},
                      {1'b1, p_wa, p_wd});
            if (bus.in_valid && bus.in_ready) begin
                exp_y.push_back(bus.in_a ^ bus.in_b);
                exp_bus.push_back({1'b1, 3'd4, bus.in_a});
                exp_bus.push_back({1'b1, 3'd5, bus.in_b});
                exp_bus.push_back({1'b0, 3'd3, 1'b0});
                acc_cyc.push_back(cyc);
            end
            if (bus.write_en && bus.write_rdy) begin
                if (exp_bus.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    m_ev = exp_bus.pop_front();
                    check("wr_xfer", {1'b1, bus.write_address, bus.write_data}, m_ev);
                end
            end
            if (bus.read_en && bus.read_rdy) begin
                if (exp_bus.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    m_ev = exp_bus.pop_front();
                    check("rd_xfer", {1'b0, bus.read_address, 1'b0}, m_ev);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_y.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    m_y   = exp_y.pop_front();
                    m_acc = acc_cyc.pop_front();
                    check("out_y", bus.out_y, m_y);
                    check("out_y_w2", {bus2.out_valid, bus2.out_y}, {1'b1, m_y});
                    if (ideal) check("latency", cyc - m_acc, 5);
                end
                n_done++;
            end
            p_ov = bus.out_valid; p_or = bus.out_ready; p_y = bus.out_y;
            p_we = bus.write_en;  p_wr = bus.write_rdy;
            p_wa = bus.write_address; p_wd = bus.write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            bus.write_rdy = ($urandom_range(0, 3) != 0);
            bus.read_rdy  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0; bus.write_rdy = 1'b1; bus.read_rdy = 1'b1; bus.out_ready = 1'b1;
        hold_status = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic send_pair(input logic a, input logic b);
        bit acc = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            done = (exp_y.size() == 0) && bus.in_ready;
            tick();
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   found;
        int   exp2 [5] = '{1, 2, 3, 0, 1};
        RST = 1'b1; rnd = 1'b0; hold_status = 1'b0; ideal = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0;
        bus.out_ready = 1'b1; bus.write_rdy = 1'b1; bus.read_rdy = 1'b1;
        tick();
        @(negedge clk);
        check("rst_outputs", {bus.out_valid, bus.out_y, bus.write_en, bus.read_en,
              bus.write_address, bus.read_address, bus.write_data, err}, 0);
        check("rst_count", done_count, 0);
        tick();
        RST = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        tick();

        // all four operand pairs, ideal slave
        ideal = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(i[1], i[0]);
        drain();
        check("count_after_4", done_count, 4);
        ideal = 1'b0;

        // write_rdy low three cycles in WR_A
        do_reset();
        bus.write_rdy = 1'b0;
        send_pair(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_wr_a", {bus.write_en, bus.write_address, bus.write_data}, {1'b1, 3'd4, 1'b1});
            tick();
            if (i == 2) bus.write_rdy = 1'b1;
        end
        @(negedge clk);
        check("stall_then_wr_b", {bus.write_en, bus.write_address, bus.write_data}, {1'b1, 3'd5, 1'b0});
        tick();
        drain();

        // progress on the last allowed WR_A cycle beats the timeout
        do_reset();
        bus.write_rdy = 1'b0;
        send_pair(1'b0, 1'b1);
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("edge_no_err", err, 0);
            tick();
            if (i == int'(TO) - 2) bus.write_rdy = 1'b1;
        end
        @(negedge clk);
        check("edge_reached_wr_b", {err, bus.write_address}, {1'b0, 3'd5});
        tick();
        drain();

        // status stuck at 0 in POLL -> sticky error
        do_reset();
        hold_status = 1'b1;
        send_pair(1'b0, 1'b1);
        tick();
        tick();
        for (int i = 0; i < int'(TO); i++) begin
            @(negedge clk);
            check("poll_wait", {err, bus.read_address}, {1'b0, 3'd2});
            tick();
        end
        @(negedge clk);
        check("poll_timeout", {err, bus.write_en, bus.read_en, bus.in_ready, bus.out_valid}, 5'b10000);
        tick();
        bus.in_valid = 1'b1;
        hold_status = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("err_sticky", {err, bus.in_ready, bus.write_en, bus.read_en}, 4'b1000);
            tick();
        end
        bus.in_valid = 1'b0;

        // consumer back-pressure for ten cycles
        do_reset();
        bus.out_ready = 1'b0;
        send_pair(1'b1, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = bus.out_valid;
            if (!found) tick();
        end
        check("out_valid_seen", found, 1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {bus.out_valid, bus.out_y, bus.in_ready}, 3'b110);
            check("bp_count", done_count, 0);
            tick();
            @(negedge clk);
        end
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {bus.out_valid, bus.out_y, done_count}, {2'b11, 8'd0});
        tick();
        @(negedge clk);
        check("bp_done", {bus.out_valid, done_count}, {1'b0, 8'd1});
        tick();

        // reset while polling, then a fresh pair
        hold_status = 1'b1;
        send_pair(1'b1, 1'b1);
        tick(); tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        hold_status = 1'b0;
        @(negedge clk);
        check("rst_in_poll", {bus.in_ready, bus.write_en, bus.read_en, bus.out_valid, done_count}, {4'b1000, 8'd0});
        tick();
        send_pair(1'b1, 1'b0);
        drain();
        check("after_rst_count", done_count, 1);

        // 2-bit counter wrap
        do_reset();
        ideal = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drain();
            check("cnt_w2_seq", done_count2, exp2[i]);
        end
        ideal = 1'b0;

        // randomized traffic and slave timing
        do_reset();
        rnd = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain();
        rnd = 1'b0;
        check("rand_no_err", {err, err2}, 0);
        check("rand_count_wrap", done_count, 8'd44);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
